// File: rtl/fft_ctrl_pkg.sv
// rtl/fft_ctrl_pkg.sv - shared widths, back-end state type and lane packing helpers for fft_frame_ctrl
package fft_ctrl_pkg;

  localparam int DATA_W_DEF   = 12;
  localparam int N_POINTS_DEF = 8;
  localparam int LANE_IDX_W   = $clog2(N_POINTS_DEF);
  localparam int FRAME_W      = DATA_W_DEF * N_POINTS_DEF;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DRAIN
  } be_state_t;

  function automatic logic [DATA_W_DEF-1:0] lane_get(input logic [FRAME_W-1:0]    frame,
                                                     input logic [LANE_IDX_W-1:0] k);
    return frame[k*DATA_W_DEF +: DATA_W_DEF];
  endfunction

  function automatic logic [FRAME_W-1:0] lane_put(input logic [FRAME_W-1:0]    frame,
                                                  input logic [LANE_IDX_W-1:0] k,
                                                  input logic [DATA_W_DEF-1:0] v);
    logic [FRAME_W-1:0] f;
    f = frame;
    f[k*DATA_W_DEF +: DATA_W_DEF] = v;
    return f;
  endfunction

endpackage

// File: rtl/fft_sample_collector.sv
// rtl/fft_sample_collector.sv - serial-to-parallel input buffer; stalls the sample stream while a full frame waits for launch
module fft_sample_collector
  import fft_ctrl_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int N_POINTS = N_POINTS_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [DATA_W-1:0]            sample_in,
  input  logic                         sample_valid,
  output logic                         sample_ready,
  input  logic                         clear,
  output logic                         full,
  output logic [N_POINTS*DATA_W-1:0]   frame
);

  localparam int              PTR_W    = $clog2(N_POINTS);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_POINTS - 1);

  logic [PTR_W-1:0]  wr_ptr;
  logic [DATA_W-1:0] lanes [N_POINTS];
  logic              accept;

  // Ready depends only on registered state, never on sample_valid.
  assign sample_ready = !full;
  assign accept       = sample_valid && !full;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      full   <= 1'b0;
      for (int k = 0; k < N_POINTS; k++) lanes[k] <= '0;
    end else begin
      if (clear) full <= 1'b0;
      if (accept) begin
        lanes[wr_ptr] <= sample_in;
        if (wr_ptr == PTR_LAST) begin
          wr_ptr <= '0;
          full   <= 1'b1;
        end else begin
          wr_ptr <= wr_ptr + 1'b1;
        end
      end
    end
  end

  for (genvar k = 0; k < N_POINTS; k++) begin : g_pack
    assign frame[k*DATA_W +: DATA_W] = lanes[k];
  end

endmodule

// File: rtl/fft_frame_ctrl.sv
// rtl/fft_frame_ctrl.sv - frame sequencer around an N-point FFT core: collect, launch, wait out latency, stream bins
module fft_frame_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEF,
  parameter int N_POINTS      = N_POINTS_DEF,
  parameter int FFT_LATENCY   = 3,
  parameter bit HALF_SPECTRUM = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [DATA_W-1:0]             sample_in,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  output logic [N_POINTS*DATA_W-1:0]    fft_x,
  input  logic [N_POINTS*DATA_W-1:0]    fft_y_r,
  input  logic [N_POINTS*DATA_W-1:0]    fft_y_i,
  output logic [DATA_W-1:0]             out_re,
  output logic [DATA_W-1:0]             out_im,
  output logic [$clog2(N_POINTS)-1:0]   out_idx,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic                          frame_done,
  output logic                          busy
);

  localparam int               IDX_W     = $clog2(N_POINTS);
  localparam int               CNT_W     = (FFT_LATENCY < 1) ? 1 : $clog2(FFT_LATENCY + 1);
  localparam logic [IDX_W-1:0] LAST      = HALF_SPECTRUM ? IDX_W'(N_POINTS / 2) : IDX_W'(N_POINTS - 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(FFT_LATENCY);

  be_state_t                   state, state_d;
  logic [CNT_W-1:0]            wait_cnt;
  logic                        full, launch, capture, last_hs;
  logic [N_POINTS*DATA_W-1:0]  frame;
  logic [DATA_W-1:0]           obuf_re [N_POINTS];
  logic [DATA_W-1:0]           obuf_im [N_POINTS];

  fft_sample_collector #(
    .DATA_W   (DATA_W),
    .N_POINTS (N_POINTS)
  ) u_collector (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .clear        (launch),
    .full         (full),
    .frame        (frame)
  );

  always_comb begin
    state_d = state;
    launch  = 1'b0;
    capture = 1'b0;
    last_hs = 1'b0;
    case (state)
      IDLE: if (full) begin
        launch  = 1'b1;
        state_d = WAIT;
      end
      WAIT: if (wait_cnt == '0) begin
        capture = 1'b1;
        state_d = DRAIN;
      end
      DRAIN: if (out_ready && out_idx == LAST) begin
        last_hs = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      fft_x      <= '0;
      out_idx    <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      for (int k = 0; k < N_POINTS; k++) begin
        obuf_re[k] <= '0;
        obuf_im[k] <= '0;
      end
    end else begin
      state      <= state_d;
      frame_done <= last_hs;
      // fft_x is only ever loaded here, so the core sees a stable frame for the whole wait.
      if (launch) begin
        fft_x    <= frame;
        wait_cnt <= WAIT_LOAD;
      end else if (state == WAIT && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - 1'b1;
      end
      if (capture) begin
        for (int k = 0; k < N_POINTS; k++) begin
          obuf_re[k] <= fft_y_r[k*DATA_W +: DATA_W];
          obuf_im[k] <= fft_y_i[k*DATA_W +: DATA_W];
        end
        out_idx   <= '0;
        out_valid <= 1'b1;
      end else if (state == DRAIN && out_ready) begin
        if (last_hs) begin
          out_valid <= 1'b0;
          out_idx   <= '0;
        end else begin
          out_idx <= out_idx + 1'b1;
        end
      end
    end
  end

  assign out_re   = obuf_re[out_idx];
  assign out_im   = obuf_im[out_idx];
  assign out_last = out_valid && (out_idx == LAST);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb/tb_fft_frame_ctrl.sv - scoreboard bench for fft_frame_ctrl, full- and half-spectrum instances
`timescale 1ns/1ps
module tb_fft_frame_ctrl;
  import fft_ctrl_pkg::*;

  localparam int DW = DATA_W_DEF;
  localparam int NP = N_POINTS_DEF;
  localparam int FW = DW * NP;
  localparam int IW = $clog2(NP);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, flush, sample_valid, out_ready;
  logic [DW-1:0] sample_in;

  logic          sample_ready, out_valid, out_last, frame_done, busy;
  logic [FW-1:0] fft_x, fft_y_r, fft_y_i;
  logic [DW-1:0] out_re, out_im;
  logic [IW-1:0] out_idx;

  logic          sample_ready_h, out_valid_h, out_last_h, frame_done_h, busy_h;
  logic [FW-1:0] fft_x_h, fft_y_r_h, fft_y_i_h;
  logic [DW-1:0] out_re_h, out_im_h;
  logic [IW-1:0] out_idx_h;

  fft_frame_ctrl #(.DATA_W(DW), .N_POINTS(NP), .FFT_LATENCY(3), .HALF_SPECTRUM(1'b0)) dut (
    .clk(clk), .rst(rst), .flush(flush), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .fft_x(fft_x), .fft_y_r(fft_y_r), .fft_y_i(fft_y_i),
    .out_re(out_re), .out_im(out_im), .out_idx(out_idx), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .frame_done(frame_done), .busy(busy)
  );

  fft_frame_ctrl #(.DATA_W(DW), .N_POINTS(NP), .FFT_LATENCY(3), .HALF_SPECTRUM(1'b1)) dut_h (
    .clk(clk), .rst(rst), .flush(flush), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready_h), .fft_x(fft_x_h), .fft_y_r(fft_y_r_h), .fft_y_i(fft_y_i_h),
    .out_re(out_re_h), .out_im(out_im_h), .out_idx(out_idx_h), .out_valid(out_valid_h),
    .out_ready(out_ready), .out_last(out_last_h), .frame_done(frame_done_h), .busy(busy_h)
  );

  // FFT stand-in: y_r = x + 15, y_i = 1 - x per lane, through three register stages.
  function automatic logic [FW-1:0] stub_re(input logic [FW-1:0] x);
    logic [FW-1:0] y = '0;
    for (int k = 0; k < NP; k++) y = lane_put(y, IW'(k), lane_get(x, IW'(k)) + DW'(15));
    return y;
  endfunction

  function automatic logic [FW-1:0] stub_im(input logic [FW-1:0] x);
    logic [FW-1:0] y = '0;
    for (int k = 0; k < NP; k++) y = lane_put(y, IW'(k), DW'(1) - lane_get(x, IW'(k)));
    return y;
  endfunction

  logic [FW-1:0] pr [3], pi [3], prh [3], pih [3];
  always @(posedge clk) begin
    pr[0]  <= stub_re(fft_x);   pr[1]  <= pr[0];  pr[2]  <= pr[1];
    pi[0]  <= stub_im(fft_x);   pi[1]  <= pi[0];  pi[2]  <= pi[1];
    prh[0] <= stub_re(fft_x_h); prh[1] <= prh[0]; prh[2] <= prh[1];
    pih[0] <= stub_im(fft_x_h); pih[1] <= pih[0]; pih[2] <= pih[1];
  end
  assign fft_y_r   = pr[2];
  assign fft_y_i   = pi[2];
  assign fft_y_r_h = prh[2];
  assign fft_y_i_h = pih[2];

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic [IW-1:0] idx;
    logic          last;
  } bin_t;

  bin_t exp_q [$];
  int   total = 0;
  int   bad = 0;
  int   hs_cnt = 0;
  logic mon_half = 1'b0;
  logic fd_pending = 1'b0;
  logic stall_prev = 1'b0;
  bin_t stall_val;

  // Scoreboard consumer: pops on every handshake of the selected instance.
  always @(negedge clk) begin
    logic          v, l, fd;
    logic [DW-1:0] re, im;
    logic [IW-1:0] idx;
    bin_t          e;
    v   = mon_half ? out_valid_h  : out_valid;
    l   = mon_half ? out_last_h   : out_last;
    fd  = mon_half ? frame_done_h : frame_done;
    re  = mon_half ? out_re_h     : out_re;
    im  = mon_half ? out_im_h     : out_im;
    idx = mon_half ? out_idx_h    : out_idx;
    if (rst || flush) begin
      fd_pending = 1'b0;
      stall_prev = 1'b0;
    end else begin
      if (fd === 1'b1 || fd_pending) begin
        total++;
        if (fd !== fd_pending) begin
          bad++;
          $display("FAIL frame_done: got %b want %b at %0t", fd, fd_pending, $time);
        end
      end
      fd_pending = 1'b0;
      if (stall_prev) begin
        total++;
        if ({re, im, idx, l} !== stall_val || v !== 1'b1) begin
          bad++;
          $display("FAIL bin_hold: got re=%0d im=%0d idx=%0d valid=%b want re=%0d im=%0d idx=%0d valid=1 at %0t",
                   re, im, idx, v, stall_val.re, stall_val.im, stall_val.idx, $time);
        end
      end
      stall_prev = (v === 1'b1 && out_ready === 1'b0);
      stall_val  = {re, im, idx, l};
      if (v === 1'b1 && out_ready === 1'b1) begin
        total++;
        hs_cnt++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL bin_extra: got idx=%0d re=%0d im=%0d want no bin at %0t", idx, re, im, $time);
        end else begin
          e = exp_q.pop_front();
          if ({re, im, idx, l} !== e) begin
            bad++;
            $display("FAIL bin: got re=%0d im=%0d idx=%0d last=%b want re=%0d im=%0d idx=%0d last=%b at %0t",
                     re, im, idx, l, e.re, e.im, e.idx, e.last, $time);
          end
          if (e.last) fd_pending = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic send_sample(input logic [DW-1:0] v);
    int n = 0;
    sample_in    = v;
    sample_valid = 1'b1;
    while (sample_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL sample_accept_timeout: got ready=%b want 1 within 200 cycles", sample_ready);
    end
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic send_frame(input int first, output logic [FW-1:0] x);
    x = '0;
    for (int k = 0; k < NP; k++) begin
      x = lane_put(x, IW'(k), DW'(first + k));
      send_sample(DW'(first + k));
    end
  endtask

  task automatic push_frame(input logic [FW-1:0] x, input bit half);
    int last_k = half ? NP / 2 : NP - 1;
    for (int k = 0; k <= last_k; k++) begin
      bin_t b;
      b.re   = lane_get(x, IW'(k)) + DW'(15);
      b.im   = DW'(1) - lane_get(x, IW'(k));
      b.idx  = IW'(k);
      b.last = (k == last_k);
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || (mon_half ? busy_h : busy) !== 1'b0) && n < 400) begin
      tick();
      n++;
    end
    total++;
    if (n >= 400) begin
      bad++;
      $display("FAIL %s_timeout: got %0d bins pending want 0 after %0d cycles", name, exp_q.size(), n);
    end
    tick();
    tick();
  endtask

  task automatic test_reset();
    logic [FW-1:0] x;
    int n = 0;
    rst = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0;
    total++; if (out_valid !== 1'b0)    begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    total++; if (busy !== 1'b0)         begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (fft_x !== '0)          begin bad++; $display("FAIL rst_fft_x: got %h want 0", fft_x); end
    total++; if (sample_ready !== 1'b1) begin bad++; $display("FAIL rst_sample_ready: got %b want 1", sample_ready); end
    total++; if ({out_re, out_im, out_idx, out_last, frame_done} !== '0)
      begin bad++; $display("FAIL rst_out_bus: got re=%h im=%h idx=%h last=%b fd=%b want all 0",
                            out_re, out_im, out_idx, out_last, frame_done); end
    total++; if (sample_ready_h !== 1'b1) begin bad++; $display("FAIL rst_sample_ready_h: got %b want 1", sample_ready_h); end
    // Abort mid-DRAIN with downstream stalled.
    out_ready = 1'b0;
    send_frame(1, x);
    while (out_valid !== 1'b1 && n < 50) begin tick(); n++; end
    total++; if (n >= 50) begin bad++; $display("FAIL drain_reach_timeout: got out_valid=%b want 1", out_valid); end
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (out_valid !== 1'b0)    begin bad++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
    total++; if (busy !== 1'b0)         begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
    total++; if (fft_x !== '0)          begin bad++; $display("FAIL midrst_fft_x: got %h want 0", fft_x); end
    total++; if (sample_ready !== 1'b1) begin bad++; $display("FAIL midrst_sample_ready: got %b want 1", sample_ready); end
    total++; if (frame_done !== 1'b0)   begin bad++; $display("FAIL midrst_frame_done: got %b want 0", frame_done); end
    tick(); tick(); tick();
  endtask

  task automatic test_latency();
    logic [FW-1:0] x;
    int n = 0;
    do_reset();
    mon_half  = 1'b0;
    out_ready = 1'b1;
    hs_cnt    = 0;
    send_frame(1, x);
    push_frame(x, 1'b0);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL launch_early: got busy=%b want 0", busy); end
    tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL launch_edge: got busy=%b want 1", busy); end
    total++; if (fft_x !== x)   begin bad++; $display("FAIL launch_fft_x: got %h want %h", fft_x, x); end
    while (out_valid !== 1'b1 && n < 20) begin tick(); n++; end
    total++; if (n != 4) begin bad++; $display("FAIL capture_latency: got %0d cycles want 4", n); end
    wait_done("latency");
    total++; if (hs_cnt != 8) begin bad++; $display("FAIL latency_bins: got %0d want 8", hs_cnt); end
  endtask

  task automatic test_backpressure();
    logic [FW-1:0] x;
    do_reset();
    out_ready = 1'b0;
    hs_cnt    = 0;
    send_frame(40, x);
    push_frame(x, 1'b0);
    for (int i = 0; i < 400; i++) begin
      out_ready = (i % 4 == 0) || (i % 4 == 3);
      tick();
      if (exp_q.size() == 0 && busy === 1'b0) break;
    end
    out_ready = 1'b1;
    wait_done("backpressure");
    total++; if (hs_cnt != 8) begin bad++; $display("FAIL backpressure_bins: got %0d want 8", hs_cnt); end
  endtask

  task automatic test_double_buffer();
    logic [FW-1:0] x1, x2;
    bit            held = 1'b1;
    int            n = 0;
    do_reset();
    out_ready = 1'b0;
    hs_cnt    = 0;
    send_frame(200, x1);
    push_frame(x1, 1'b0);
    send_frame(300, x2);
    push_frame(x2, 1'b0);
    total++; if (out_valid !== 1'b1 || hs_cnt != 0)
      begin bad++; $display("FAIL dbuf_in_drain: got valid=%b hs=%0d want 1 and 0", out_valid, hs_cnt); end
    total++; if (sample_ready !== 1'b0) begin bad++; $display("FAIL dbuf_full_ready: got %b want 0", sample_ready); end
    tick(); tick(); tick(); tick(); tick();
    total++; if (fft_x !== x1 || sample_ready !== 1'b0)
      begin bad++; $display("FAIL dbuf_hold: got x=%h ready=%b want x=%h ready=0", fft_x, sample_ready, x1); end
    out_ready = 1'b1;
    while (frame_done !== 1'b1 && n < 40) begin
      tick();
      n++;
      if (frame_done !== 1'b1 && fft_x !== x1) held = 1'b0;
    end
    total++; if (n >= 40) begin bad++; $display("FAIL dbuf_done_timeout: got frame_done=%b want 1", frame_done); end
    total++; if (!held || fft_x !== x1)
      begin bad++; $display("FAIL dbuf_fft_x_early: got %h want %h until last handshake", fft_x, x1); end
    tick();
    total++; if (fft_x !== x2)          begin bad++; $display("FAIL dbuf_second_launch: got %h want %h", fft_x, x2); end
    total++; if (sample_ready !== 1'b1) begin bad++; $display("FAIL dbuf_ready_rise: got %b want 1", sample_ready); end
    wait_done("dbuf");
    total++; if (hs_cnt != 16) begin bad++; $display("FAIL dbuf_bins: got %0d want 16", hs_cnt); end
  endtask

  task automatic test_half_spectrum();
    logic [FW-1:0] x;
    do_reset();
    mon_half  = 1'b1;
    out_ready = 1'b1;
    hs_cnt    = 0;
    send_frame(60, x);
    push_frame(x, 1'b1);
    wait_done("half");
    tick(); tick(); tick(); tick();
    total++; if (hs_cnt != 5) begin bad++; $display("FAIL half_bins: got %0d want 5", hs_cnt); end
    do_reset();
    mon_half = 1'b0;
  endtask

  task automatic test_flush();
    logic [FW-1:0] x;
    do_reset();
    out_ready = 1'b1;
    hs_cnt    = 0;
    for (int k = 0; k < 5; k++) send_sample(DW'(51 + k));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++; if (sample_ready !== 1'b1 || busy !== 1'b0 || fft_x !== '0)
      begin bad++; $display("FAIL flush_state: got ready=%b busy=%b x=%h want 1 0 0", sample_ready, busy, fft_x); end
    send_frame(101, x);
    push_frame(x, 1'b0);
    tick();
    total++; if (fft_x !== x) begin bad++; $display("FAIL flush_fft_x: got %h want %h", fft_x, x); end
    wait_done("flush");
    total++; if (hs_cnt != 8) begin bad++; $display("FAIL flush_bins: got %0d want 8", hs_cnt); end
  endtask

  initial begin
    rst          = 1'b1;
    flush        = 1'b0;
    sample_valid = 1'b0;
    sample_in    = '0;
    out_ready    = 1'b0;
    test_reset();
    test_latency();
    test_backpressure();
    test_double_buffer();
    test_half_spectrum();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want finish within 500us");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fft_frame_ctrl.md
Name: fft_frame_ctrl

Overview:
Sequencer for the 8-point FFT datapath in the audio-processing chain. It collects serial 12-bit audio samples into an 8-sample frame and presents the frame in parallel to the FFT core. It holds the FFT inputs stable for the core's pipeline latency, then captures the 8 complex bins and streams them out serially with a valid/ready handshake. A double buffer lets the next frame be collected while the current frame drains.

Parameters:
DATA_W, 12, sample and bin component width
N_POINTS, 8, FFT size (power of 2)
FFT_LATENCY, 3, registered stages between FFT input change and valid output
HALF_SPECTRUM, 0, 1 = emit bins 0..N_POINTS/2 only (real-input symmetry)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active high
flush  in  1  synchronous abort of all frames in progress
sample_in  in  DATA_W  audio sample
sample_valid  in  1  sample_in valid
sample_ready  out  1  controller can accept a sample
fft_x  out  N_POINTS*DATA_W  FFT inputs; lane k at [k*DATA_W +: DATA_W]
fft_y_r  in  N_POINTS*DATA_W  FFT real outputs, same lane packing
fft_y_i  in  N_POINTS*DATA_W  FFT imaginary outputs
out_re  out  DATA_W  bin real part
out_im  out  DATA_W  bin imaginary part
out_idx  out  log2(N_POINTS)  bin index
out_valid  out  1  bin valid
out_ready  in  1  downstream accepts bin
out_last  out  1  final bin of frame
frame_done  out  1  one-cycle pulse after final bin handshake
busy  out  1  back end not IDLE

Behaviour:
- Reset (rst=1) and flush both apply on the same edge. Write pointer=0, collect-full=0, back end=IDLE, fft_x=0, out_re/out_im/out_idx=0, out_valid=out_last=frame_done=busy=0. A frame in flight is discarded and no frame_done is issued.
- Collector:
  - sample_ready = !full (registered state, no combinational path from sample_valid).
  - On sample_valid&&sample_ready, sample_in is stored in input-buffer lane wr_ptr and wr_ptr increments.
  - Accepting lane N_POINTS-1 sets full and wraps wr_ptr to 0.
- Back-end FSM, states IDLE -> WAIT -> DRAIN -> IDLE:
  - IDLE: if full, launch. Copy the input buffer into the fft_x register, clear full, load wait_cnt=FFT_LATENCY, go to WAIT. Launch happens at the earliest one cycle after the 8th sample is accepted.
  - WAIT: decrement wait_cnt each cycle. When wait_cnt==0, register all fft_y_r/fft_y_i lanes into the output buffer, go to DRAIN, and set out_valid=1, out_idx=0. Capture edge = launch edge + FFT_LATENCY + 1.
  - DRAIN: out_re/out_im = output-buffer lane out_idx. While out_valid && !out_ready, all out_* are held stable. On handshake, out_idx increments.
    - out_last=1 when out_idx==LAST, where LAST = N_POINTS-1, or N_POINTS/2 if HALF_SPECTRUM.
    - Handshake at LAST: out_valid=0, out_last=0, frame_done=1 for one cycle, go to IDLE.
- fft_x changes only on a launch (or reset/flush). The collector keeps accepting during WAIT/DRAIN until full. When full, sample_ready=0 until the next launch; sample_ready rises the cycle after the launch edge.
- busy = state!=IDLE.
- Sample values pass through unmodified (no scaling, sign handled by the FFT core).
- No input is ever dropped: overflow is prevented by back-pressure alone.

Decomposition:
- Package fft_ctrl_pkg holds:
  - DATA_W and N_POINTS defaults
  - lane-index width constant
  - back-end state enum (IDLE, WAIT, DRAIN)
  - lane pack/unpack helper functions
- Sub-module fft_sample_collector holds the input buffer, wr_ptr and full flag. It exposes sample_ready, full, the packed frame, and a launch/clear input.

Test Plan:
- Reset and idle. Pulse rst mid-DRAIN -> next cycle out_valid=0, busy=0, fft_x=0, sample_ready=1, no frame_done.
- Latency. Stream samples 1..8 with valid held high; FFT stub echoes y_r lane k = 16+k, y_i = -k.
  - fft_x lanes = 1..8 one cycle after launch.
  - Capture exactly 4 cycles after launch with FFT_LATENCY=3.
  - out sequence re 16..23, im 0..-7, idx 0..7.
  - out_last on idx 7; frame_done one cycle after the last handshake.
- Back-pressure. out_ready toggles 1,0,0,1,... -> each bin held stable while out_ready=0, no bin skipped or repeated, total 8 handshakes.
- Double buffer / full. Send 16 samples back-to-back with out_ready=0.
  - Second frame is accepted during DRAIN.
  - sample_ready=0 after sample 16.
  - fft_x unchanged until the first frame's 8th handshake.
  - The second launch then occurs and sample_ready rises.
- HALF_SPECTRUM=1 -> exactly 5 bins (idx 0..4), out_last on idx 4, frame_done after idx 4.
- Flush. Assert flush after 5 samples accepted -> wr_ptr restarts. The next 8 samples (101..108) appear as fft_x lanes 0..7 with no residue of the first 5.
